// File: rtl/param_sync_fifo.sv
// param_sync_fifo: parametrised single-clock FIFO with occupancy count and sticky errors.
// Define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module param_sync_fifo #(
    parameter int DW        = 8,
    parameter int AW        = 4,
    parameter int AFULL_TH  = 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          rd_valid,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          a_full,
    output logic          a_empty,
    output logic          ovf,
    output logic          udf
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_LVL  = (AW+1)'(DEPTH - AFULL_TH);
    localparam logic [AW:0] AE_LVL  = (AW+1)'(AEMPTY_TH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt_next;
    logic          rd_ok;
    logic          wr_ok;

    always_comb begin
        full    = (count == CNT_MAX);
        empty   = (count == '0);
        a_full  = (count >= AF_LVL);
        a_empty = (count <= AE_LVL);
    end

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign rd_ok = pop & ~empty;
    assign wr_ok = push & (~full | rd_ok);

    always_comb begin
        cnt_next = count;
        unique case ({wr_ok, rd_ok})
            2'b10:   cnt_next = count + 1'b1;
            2'b01:   cnt_next = count - 1'b1;
            default: cnt_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn && !clr && wr_ok)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok)
                rd_ptr <= rd_ptr + 1'b1;
            count <= cnt_next;
            if (push && !wr_ok)
                ovf <= 1'b1;
            if (pop && !rd_ok)
                udf <= 1'b1;
        end
    end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    assign dout     = empty ? '0 : mem[rd_ptr];
    assign rd_valid = ~empty;
`else
    logic [DW-1:0] dout_q;
    logic          rv_q;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            dout_q <= '0;
            rv_q   <= 1'b0;
        end else if (clr) begin
            dout_q <= '0;
            rv_q   <= 1'b0;
        end else begin
            rv_q <= rd_ok;
            if (rd_ok)
                dout_q <= mem[rd_ptr];
        end
    end

    assign dout     = dout_q;
    assign rd_valid = rv_q;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo (DEPTH=4) using a queue-based model.
// Directed table, hand sequences for wrap/flush/async reset, then random traffic.
module tb_param_sync_fifo;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rstn, clr, push, pop;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          rd_valid;
    logic [AW:0]   count;
    logic          full, empty, a_full, a_empty, ovf, udf;

    int total = 0;
    int bad   = 0;

    logic [7:0] q[$];
    logic       m_ovf, m_udf, m_rv;
    logic [7:0] m_dout;

    param_sync_fifo #(.DW(DW), .AW(AW), .AFULL_TH(1), .AEMPTY_TH(1)) dut (
        .clk(clk), .rstn(rstn), .clr(clr), .push(push), .pop(pop),
        .din(din), .dout(dout), .rd_valid(rd_valid), .count(count),
        .full(full), .empty(empty), .a_full(a_full), .a_empty(a_empty),
        .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       push, pop, clr;
        logic [7:0] din;
        int         cnt;
        logic [3:0] flg;
        logic [7:0] d;
        logic       rv, ov, ud;
    } vec_t;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        m_ovf = 1'b0; m_udf = 1'b0; m_rv = 1'b0; m_dout = '0;
    endfunction

    function automatic void model_edge(logic p, logic r, logic c, logic [7:0] d);
        bit rd, wr;
        logic [7:0] v;
        if (c) begin
            model_reset();
            return;
        end
        rd = r && q.size() > 0;
        wr = p && (q.size() < DEPTH || rd);
        v = 8'h00;
        if (rd) v = q.pop_front();
        if (wr) q.push_back(d);
        if (p && !wr) m_ovf = 1'b1;
        if (r && !rd) m_udf = 1'b1;
        m_rv = rd;
        if (rd) m_dout = v;
    endfunction

    task automatic check_model(string tag);
        int n;
        logic [7:0] ed;
        logic er;
        n = q.size();
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        ed = (n > 0) ? q[0] : 8'h00;
        er = (n > 0);
`else
        ed = m_dout;
        er = m_rv;
`endif
        chk({tag, ".count"}, int'(count), n);
        chk({tag, ".full"}, int'(full), int'(n == DEPTH));
        chk({tag, ".empty"}, int'(empty), int'(n == 0));
        chk({tag, ".a_full"}, int'(a_full), int'(n >= DEPTH - 1));
        chk({tag, ".a_empty"}, int'(a_empty), int'(n <= 1));
        chk({tag, ".ovf"}, int'(ovf), int'(m_ovf));
        chk({tag, ".udf"}, int'(udf), int'(m_udf));
        chk({tag, ".dout"}, int'(dout), int'(ed));
        chk({tag, ".rd_valid"}, int'(rd_valid), int'(er));
    endtask

    task automatic step(logic p, logic r, logic c, logic [7:0] d, string tag);
        push = p; pop = r; clr = c; din = d;
        @(posedge clk);
        model_edge(p, r, c, d);
        #1;
        push = 1'b0; pop = 1'b0; clr = 1'b0;
        check_model(tag);
    endtask

    vec_t vt[14];

    initial begin
        vt[0]  = '{1,0,0,8'h10, 1,4'b0001,8'h00,0,0,0};
        vt[1]  = '{1,0,0,8'h11, 2,4'b0000,8'h00,0,0,0};
        vt[2]  = '{1,0,0,8'h12, 3,4'b0010,8'h00,0,0,0};
        vt[3]  = '{1,0,0,8'h13, 4,4'b1010,8'h00,0,0,0};
        vt[4]  = '{1,0,0,8'h99, 4,4'b1010,8'h00,0,1,0};
        vt[5]  = '{0,1,0,8'h00, 3,4'b0010,8'h10,1,1,0};
        vt[6]  = '{0,0,0,8'h00, 3,4'b0010,8'h10,0,1,0};
        vt[7]  = '{0,1,0,8'h00, 2,4'b0000,8'h11,1,1,0};
        vt[8]  = '{0,1,0,8'h00, 1,4'b0001,8'h12,1,1,0};
        vt[9]  = '{0,1,0,8'h00, 0,4'b0101,8'h13,1,1,0};
        vt[10] = '{0,1,0,8'h00, 0,4'b0101,8'h13,0,1,1};
        vt[11] = '{1,1,0,8'h20, 1,4'b0001,8'h13,0,1,1};
        vt[12] = '{0,1,0,8'h00, 0,4'b0101,8'h20,1,1,1};
        vt[13] = '{0,0,1,8'h00, 0,4'b0101,8'h00,0,0,0};

        rstn = 1'b1; clr = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_model("reset");
        rstn = 1'b0;

        for (int i = 0; i < 14; i++) begin
            step(vt[i].push, vt[i].pop, vt[i].clr, vt[i].din, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.cnt_tbl", i), int'(count), vt[i].cnt);
            chk($sformatf("vec%0d.flg_tbl", i),
                int'({full, empty, a_full, a_empty}), int'(vt[i].flg));
            chk($sformatf("vec%0d.ovf_tbl", i), int'(ovf), int'(vt[i].ov));
            chk($sformatf("vec%0d.udf_tbl", i), int'(udf), int'(vt[i].ud));
`ifndef PARAM_SYNC_FIFO_FWFT_EN
            chk($sformatf("vec%0d.dout_tbl", i), int'(dout), int'(vt[i].d));
            chk($sformatf("vec%0d.rv_tbl", i), int'(rd_valid), int'(vt[i].rv));
`endif
        end

        // Full with simultaneous push/pop, then stream across the wrap.
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 1'b0, 8'(8'h10 + i), "fill");
        step(1'b1, 1'b1, 1'b0, 8'h30, "fullpp");
        chk("fullpp.cnt", int'(count), 4);
`ifndef PARAM_SYNC_FIFO_FWFT_EN
        chk("fullpp.dout", int'(dout), 8'h10);
`endif
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, 1'b0, 8'(8'h50 + i), "wrap");

        // Flush with count=3 and ovf set.
        step(1'b1, 1'b0, 1'b0, 8'hee, "ovf");
        step(1'b0, 1'b1, 1'b0, 8'h00, "pre_clr");
        chk("pre_clr.cnt", int'(count), 3);
        chk("pre_clr.ovf", int'(ovf), 1);
        step(1'b0, 1'b0, 1'b1, 8'h00, "clr");
        chk("clr.cnt", int'(count), 0);
        chk("clr.dout", int'(dout), 0);

        // Asynchronous reset mid-stream, checked before the next edge.
        step(1'b1, 1'b0, 1'b0, 8'h61, "pre_rst");
        step(1'b1, 1'b1, 1'b0, 8'h62, "pre_rst");
        push = 1'b1; din = 8'h63;
        #2;
        rstn = 1'b1;
        #1;
        model_reset();
        check_model("arst");
        push = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        step(1'b1, 1'b0, 1'b0, 8'h70, "post_rst");
        chk("post_rst.cnt", int'(count), 1);

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 59) == 0, 8'($urandom), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
